// File: rtl/dm_byte_responder.sv
// M-stage data memory responder: byte-enabled stores, extended loads, fixed wait states.
// Optional ALIGN_CHECK_EN adds misalign_err and suppresses misaligned accesses.
module dm_byte_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_ldtype,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        busy
`ifdef ALIGN_CHECK_EN
  ,
  output logic        misalign_err
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam bit NO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0] CNT_LAST =
    4'(NO_WAIT ? 0 : WAIT_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic          lat_we;
  logic [3:0]    lat_be;
  logic [AW+1:0] lat_addr;
  logic [31:0]   lat_wdata;
  logic [2:0]    lat_lt;
  logic          err_q;
  logic [31:0]   rd_word;
  logic [31:0]   ext;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          accept;
  logic          enter_resp;
  logic          a_we;
  logic [3:0]    a_be;
  logic [AW+1:0] a_addr;
  logic [31:0]   a_wdata;
  logic [AW-1:0] idx;
  logic          a_err;
  logic          unused_addr;

  assign req_ready = (state == S_IDLE);
  assign busy      = (state == S_WAIT) || (state == S_RESP);
  assign accept    = req_valid && req_ready;

  // With no wait states the access happens on the accept edge itself,
  // so the live request is used instead of the (not yet) latched copy.
  assign enter_resp = NO_WAIT ? accept
                    : (state == S_WAIT) && (cnt == CNT_LAST);
  assign a_we    = NO_WAIT ? req_we : lat_we;
  assign a_be    = NO_WAIT ? req_be : lat_be;
  assign a_addr  = NO_WAIT ? req_addr[AW+1:0] : lat_addr;
  assign a_wdata = NO_WAIT ? req_wdata : lat_wdata;
  assign idx     = a_addr[AW+1:2];

  assign unused_addr = ^req_addr;

`ifdef ALIGN_CHECK_EN
  logic [2:0] a_lt;
  assign a_lt = NO_WAIT ? req_ldtype : lat_lt;

  always_comb begin
    a_err = 1'b0;
    if (a_we) begin
      unique case (a_be)
        4'b1111: a_err = (a_addr[1:0] != 2'd0);
        4'b0011: a_err = (a_addr[1:0] != 2'd0);
        4'b1100: a_err = (a_addr[1:0] != 2'd2);
        4'b0001: a_err = (a_addr[1:0] != 2'd0);
        4'b0010: a_err = (a_addr[1:0] != 2'd1);
        4'b0100: a_err = (a_addr[1:0] != 2'd2);
        4'b1000: a_err = (a_addr[1:0] != 2'd3);
        default: a_err = 1'b1;
      endcase
    end else begin
      unique case (a_lt)
        3'b001, 3'b010: a_err = 1'b0;
        3'b011, 3'b100: a_err = a_addr[0];
        default:        a_err = (a_addr[1:0] != 2'd0);
      endcase
    end
  end
`else
  assign a_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset_n && enter_resp) begin
      rd_word <= mem[idx];
      if (a_we && !a_err) begin
        for (int i = 0; i < 4; i++) begin
          if (a_be[i]) mem[idx][8*i +: 8] <= a_wdata[8*i +: 8];
        end
      end
    end
  end

  logic [7:0]  sel_b;
  logic [15:0] sel_h;
  assign sel_b = rd_word[{lat_addr[1:0], 3'b000} +: 8];
  assign sel_h = lat_addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    ext = rd_word;
    unique case (1'b1)
      (lat_lt == 3'b001): ext = {{24{sel_b[7]}}, sel_b};
      (lat_lt == 3'b010): ext = {24'd0, sel_b};
      (lat_lt == 3'b011): ext = {{16{sel_h[15]}}, sel_h};
      (lat_lt == 3'b100): ext = {16'd0, sel_h};
      default:            ext = rd_word;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      lat_we    <= 1'b0;
      lat_be    <= 4'd0;
      lat_addr  <= '0;
      lat_wdata <= 32'd0;
      lat_lt    <= 3'd0;
      err_q     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
`ifdef ALIGN_CHECK_EN
      misalign_err <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
`ifdef ALIGN_CHECK_EN
      misalign_err <= 1'b0;
`endif
      if (accept) begin
        lat_we    <= req_we;
        lat_be    <= req_be;
        lat_addr  <= req_addr[AW+1:0];
        lat_wdata <= req_wdata;
        lat_lt    <= req_ldtype;
      end
      if (enter_resp) err_q <= a_err;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state <= NO_WAIT ? S_RESP : S_WAIT;
            cnt   <= 4'd0;
          end
        end
        S_WAIT: begin
          if (cnt == CNT_LAST) begin
            state <= S_RESP;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_RESP: begin
          state     <= S_IDLE;
          rsp_valid <= 1'b1;
          rsp_rdata <= (lat_we || err_q) ? 32'd0 : ext;
`ifdef ALIGN_CHECK_EN
          misalign_err <= err_q;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_byte_responder.sv
// Scoreboard bench for dm_byte_responder: directed loads/stores, latency,
// mid-flight reset and (with ALIGN_CHECK_EN) misalignment responses.
module tb_dm_byte_responder;

  localparam int WAITC = 3;
  localparam int DEPTH = 64;
`ifdef ALIGN_CHECK_EN
  localparam bit ALN = 1'b1;
`else
  localparam bit ALN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [3:0]  req_be = 4'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [2:0]  req_ldtype = 3'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        busy;
`ifdef ALIGN_CHECK_EN
  logic        misalign_err;
`endif

  dm_byte_responder #(
    .DEPTH_WORDS(DEPTH),
    .WAIT_CYCLES(WAITC)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_be(req_be),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_ldtype(req_ldtype),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .busy(busy)
`ifdef ALIGN_CHECK_EN
    ,
    .misalign_err(misalign_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          acc;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_acc = 0;
  int   run = 0;
  bit   chain = 1'b0;
  bit   chk_run = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!req_ready) begin
      run++;
    end else begin
      if (run != 0 && chk_run) check("ready_low_run", 32'(run), 32'(WAITC + 1));
      run = 0;
    end
    if (rsp_valid) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 rdata=%h expected no response", rsp_rdata);
      end else begin
        exp_t e;
        e = q.pop_front();
        check({e.nm, " rdata"}, rsp_rdata, e.d);
        check({e.nm, " latency"}, 32'(cyc - e.acc), 32'(WAITC + 1));
`ifdef ALIGN_CHECK_EN
        check({e.nm, " misalign"}, {31'd0, misalign_err}, {31'd0, e.e});
`endif
      end
    end
  end

  task automatic issue(input string nm, input bit we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] lt, input logic [31:0] exp,
                       input bit mis, input bit push);
    exp_t e;
    int t = 0;
    req_valid  = 1'b1;
    req_we     = we;
    req_be     = be;
    req_addr   = addr;
    req_wdata  = wdata;
    req_ldtype = lt;
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      check({nm, " accept_timeout"}, 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (chain) check({nm, " accept_gap"}, 32'(cyc - last_acc), 32'(WAITC + 2));
    last_acc = cyc;
    chain = 1'b1;
    check({nm, " busy_after_accept"}, {31'd0, busy}, 32'd1);
    if (push) begin
      e.d   = (ALN && mis) ? 32'd0 : exp;
      e.e   = ALN && mis;
      e.acc = cyc;
      e.nm  = nm;
      q.push_back(e);
    end
    // Garbage on the inputs while in flight must not leak into the access.
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_be     = 4'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    req_ldtype = 3'($urandom);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset req_ready", {31'd0, req_ready}, 32'd1);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset rsp_rdata", rsp_rdata, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    issue("sw_10", 1, 4'b1111, 32'h10, 32'hDEADBEEF, 3'd0, 32'h0, 0, 1);
    issue("lw_10", 0, 4'b0000, 32'h10, 32'h0, 3'd0, 32'hDEADBEEF, 0, 1);
    issue("sb_13", 1, 4'b1000, 32'h13, 32'h80000000, 3'd0, 32'h0, 0, 1);
    issue("lb_13", 0, 4'b0000, 32'h13, 32'h0, 3'd1, 32'hFFFFFF80, 0, 1);
    issue("lbu_13", 0, 4'b0000, 32'h13, 32'h0, 3'd2, 32'h00000080, 0, 1);
    issue("lb_10", 0, 4'b0000, 32'h10, 32'h0, 3'd1, 32'hFFFFFFEF, 0, 1);
    issue("lbu_11", 0, 4'b0000, 32'h11, 32'h0, 3'd2, 32'h000000BE, 0, 1);
    issue("sw_20", 1, 4'b1111, 32'h20, 32'h12345678, 3'd0, 32'h0, 0, 1);
    issue("sh_22", 1, 4'b1100, 32'h22, 32'h80010000, 3'd0, 32'h0, 0, 1);
    issue("lh_22", 0, 4'b0000, 32'h22, 32'h0, 3'd3, 32'hFFFF8001, 0, 1);
    issue("lhu_22", 0, 4'b0000, 32'h22, 32'h0, 3'd4, 32'h00008001, 0, 1);
    issue("lw_20", 0, 4'b0000, 32'h20, 32'h0, 3'd0, 32'h80015678, 0, 1);
    issue("lh_20", 0, 4'b0000, 32'h20, 32'h0, 3'd3, 32'h00005678, 0, 1);
    issue("lh_23", 0, 4'b0000, 32'h23, 32'h0, 3'd3, 32'hFFFF8001, 1, 1);
    issue("s_be0", 1, 4'b0000, 32'h20, 32'hFFFFFFFF, 3'd0, 32'h0, 1, 1);
    issue("lw_20b", 0, 4'b0000, 32'h20, 32'h0, 3'd0, 32'h80015678, 0, 1);
    issue("lw_11", 0, 4'b0000, 32'h11, 32'h0, 3'd0, 32'h80ADBEEF, 1, 1);
    issue("lt7_10", 0, 4'b0000, 32'h10, 32'h0, 3'd7, 32'h80ADBEEF, 0, 1);
    issue("sw_110", 1, 4'b1111, 32'h110, 32'hCAFEF00D, 3'd0, 32'h0, 0, 1);
    issue("lw_wrap", 0, 4'b0000, 32'h10, 32'h0, 3'd0, 32'hCAFEF00D, 0, 1);
    issue("lw_hi", 0, 4'b0000, 32'hFFFF0010, 32'h0, 3'd0, 32'hCAFEF00D, 0, 1);
`ifdef ALIGN_CHECK_EN
    issue("s_be6", 1, 4'b0110, 32'h20, 32'hAAAAAAAA, 3'd0, 32'h0, 1, 1);
    issue("lw_20c", 0, 4'b0000, 32'h20, 32'h0, 3'd0, 32'h80015678, 0, 1);
`endif
    issue("sw_40", 1, 4'b1111, 32'h40, 32'h11111111, 3'd0, 32'h0, 0, 1);

    // Store dropped by reset while waiting.
    issue("sw_40_rst", 1, 4'b1111, 32'h40, 32'hBADBAD00, 3'd0, 32'h0, 0, 0);
    chk_run = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("post_rst req_ready", {31'd0, req_ready}, 32'd1);
    check("post_rst busy", {31'd0, busy}, 32'd0);
    check("post_rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
    repeat (8) @(negedge clk);
    chk_run = 1'b1;
    chain = 1'b0;
    issue("lw_40", 0, 4'b0000, 32'h40, 32'h0, 3'd0, 32'h11111111, 0, 1);

    begin
      int t = 0;
      while (q.size() > 0 && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (q.size() > 0) check("drain", 32'(q.size()), 32'd0);
    end
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
